// File: rtl/cache_pkg.sv
// Shared definitions for the AXI4-Lite direct-mapped cache: FSM encoding,
// AXI response codes and a width helper.
package cache_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_AR   = 3'd1;
    localparam logic [2:0] RD_R    = 3'd2;
    localparam logic [2:0] RD_DONE = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_B    = 3'd5;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Counter width that never collapses to zero bits, even for one-word lines.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axil_dm_cache_if.sv
// AXI4-Lite bus between the cache (master) and the memory system (slave).
interface axil_dm_cache_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arprot, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_dm_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read of one
// line, byte-enabled word write, tag write with valid update, global invalidate.
module axil_dm_cache_array
    import cache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = $clog2(LINES),
    parameter int CNT_W      = clog2_min1(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv,
    input  logic [IDX_W-1:0] idx,
    input  logic [CNT_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             tag_we,
    input  logic             tag_valid,
    input  logic [TAG_W-1:0] tag_data,
    input  logic             data_we,
    input  logic [CNT_W-1:0] wr_off,
    input  logic [3:0]       data_strb,
    input  logic [31:0]      data_wdata
);
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][LINE_WORDS];
    logic [31:0]      merged;

    // NOTE: state elements use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (inv) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[idx] <= tag_valid;
        end
    end

    // NOTE: no default before the loop would leave unselected lanes undriven and infer latches.
    always_comb begin
        merged = data_q[idx][wr_off];
        for (int b = 0; b < 4; b++) begin
            if (data_strb[b]) merged[8*b +: 8] = data_wdata[8*b +: 8];
        end
    end

    // NOTE: tag/data arrays have no reset; valid_q alone says whether they mean anything.
    always_ff @(posedge clk) begin
        if (tag_we)  tag_q[idx] <= tag_data;
        if (data_we) data_q[idx][wr_off] <= merged;
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx][rd_off];

endmodule

// File: rtl/axil_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between one CPU port and
// an AXI4-Lite master; misses refill a whole line, one outstanding AR at a time.
module axil_dm_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_w_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    input  logic              inv,
    axil_dm_cache_if.master   m
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int CNT_W = clog2_min1(LINE_WORDS);

    logic [2:0]        state;
    logic [CNT_W-1:0]  refill_cnt;
    logic              err_acc, aw_pend, w_pend;
    logic [CNT_W-1:0]  cpu_off, wr_off;
    logic [IDX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]  cpu_tag, arr_tag;
    logic [ADDR_W-1:0] line_base;
    logic              arr_valid, hit, last_word, rerr, inv_now;
    logic [31:0]       arr_rdata, data_wdata;
    logic [3:0]        data_strb;
    logic              data_we, tag_we;
    logic              unused_addr_bits;

    generate
        if (OFF_W == 0) begin : g_no_off
            assign cpu_off = '0;
        end else begin : g_off
            assign cpu_off = cpu_addr[2 +: OFF_W];
        end
    endgenerate

    assign cpu_idx          = cpu_addr[2+OFF_W +: IDX_W];
    assign cpu_tag          = cpu_addr[ADDR_W-1 -: TAG_W];
    assign line_base        = {cpu_addr[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}};
    assign unused_addr_bits = ^cpu_addr[1:0];
    assign hit              = arr_valid && (arr_tag == cpu_tag);
    assign last_word        = (refill_cnt == CNT_W'(LINE_WORDS - 1));
    assign rerr             = (m.rresp != AXI_RESP_OKAY);
    assign inv_now          = (state == IDLE) && inv;

    axil_dm_cache_array #(
        .LINES(LINES), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) u_array (
        .clk(clk), .rst(rst), .inv(inv_now), .idx(cpu_idx), .rd_off(cpu_off),
        .rd_valid(arr_valid), .rd_tag(arr_tag), .rd_data(arr_rdata),
        .tag_we(tag_we), .tag_valid(!(err_acc || rerr)), .tag_data(cpu_tag),
        .data_we(data_we), .wr_off(wr_off), .data_strb(data_strb), .data_wdata(data_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            refill_cnt <= '0;
            err_acc    <= 1'b0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cpu_req && !inv) begin
                    if (cpu_w_en != 4'b0000) begin
                        state   <= WR_REQ;
                        aw_pend <= 1'b1;
                        w_pend  <= 1'b1;
                    end else if (!hit) begin
                        state      <= RD_AR;
                        refill_cnt <= '0;
                        err_acc    <= 1'b0;
                    end
                end
                RD_AR: if (m.arready) state <= RD_R;
                RD_R: if (m.rvalid) begin
                    err_acc <= err_acc || rerr;
                    if (last_word) begin
                        state <= RD_DONE;
                    end else begin
                        refill_cnt <= refill_cnt + 1'b1;
                        state      <= RD_AR;
                    end
                end
                RD_DONE: state <= IDLE;
                WR_REQ: begin
                    if (m.awready) aw_pend <= 1'b0;
                    if (m.wready)  w_pend  <= 1'b0;
                    if ((!aw_pend || m.awready) && (!w_pend || m.wready)) state <= WR_B;
                end
                WR_B: if (m.bvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The array write port is shared: refill words in RD_R, store merges in WR_B.
    always_comb begin
        cpu_ready  = 1'b0;
        cpu_err    = 1'b0;
        cpu_rdata  = '0;
        data_we    = 1'b0;
        data_strb  = 4'hF;
        data_wdata = m.rdata;
        wr_off     = refill_cnt;
        tag_we     = 1'b0;
        case (state)
            IDLE: if (cpu_req && !inv && cpu_w_en == 4'b0000 && hit) begin
                cpu_ready = 1'b1;
                cpu_rdata = arr_rdata;
            end
            RD_R: if (m.rvalid) begin
                data_we = 1'b1;
                tag_we  = last_word;
            end
            RD_DONE: begin
                cpu_ready = 1'b1;
                cpu_err   = err_acc;
                cpu_rdata = arr_rdata;
            end
            WR_B: if (m.bvalid) begin
                cpu_ready = 1'b1;
                cpu_err   = (m.bresp != AXI_RESP_OKAY);
                if (hit && m.bresp == AXI_RESP_OKAY) begin
                    data_we    = 1'b1;
                    data_strb  = cpu_w_en;
                    data_wdata = cpu_wdata;
                    wr_off     = cpu_off;
                end
            end
            default: ;
        endcase
    end

    assign m.arvalid = (state == RD_AR);
    assign m.araddr  = line_base | (ADDR_W'(refill_cnt) << 2);
    assign m.arprot  = 3'b000;
    assign m.rready  = (state == RD_R);
    assign m.awvalid = aw_pend;
    assign m.awaddr  = {cpu_addr[ADDR_W-1:2], 2'b00};
    assign m.wvalid  = w_pend;
    assign m.wdata   = cpu_wdata;
    assign m.wstrb   = cpu_w_en;
    assign m.bready  = (state == WR_B);

endmodule

// File: tb/tb_axil_dm_cache.sv
// Bench for axil_dm_cache: behavioural AXI4-Lite memory slave, line-level cache
// model (valid/tag per line, data always equals memory), directed then random accesses.
module tb_axil_dm_cache;
    localparam int LINES      = 16;
    localparam int LW         = 4;
    localparam int LINE_BYTES = LW * 4;
    localparam int SPAN       = LINES * LINE_BYTES;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [3:0]  cpu_w_en = 4'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic        inv = 1'b0;

    axil_dm_cache_if #(.ADDR_W(32)) bus ();

    axil_dm_cache #(.ADDR_W(32), .LINES(LINES), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .inv(inv), .m(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slave configuration and observation logs.
    bit          stall = 0;
    int          aw_delay = 0, w_delay = 0;
    bit          rd_err_en = 0, wr_err_en = 0;
    logic [31:0] rd_err_addr = '0, wr_err_addr = '0;
    logic [31:0] mem [4096];
    logic [31:0] ar_log[$], aw_log[$], wd_log[$];
    logic [3:0]  ws_log[$];

    // Cache model: which memory block each line holds.
    bit          ref_valid [LINES];
    int unsigned ref_tag   [LINES];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Read side of the slave.
    logic r_pend;
    int   r_wait;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= 2'b00;
            r_pend      <= 1'b0;
            r_wait      <= 0;
            for (int i = 0; i < 4096; i++) mem[i] <= 32'(i);
        end else begin
            bus.arready <= stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.arvalid && bus.arready) begin
                ar_log.push_back(bus.araddr);
                if (rd_err_en && bus.araddr == rd_err_addr) begin
                    bus.rdata <= 32'hDEAD_BEEF;
                    bus.rresp <= 2'b10;
                end else begin
                    bus.rdata <= mem[bus.araddr[13:2]];
                    bus.rresp <= 2'b00;
                end
                if (stall) begin
                    r_pend <= 1'b1;
                    r_wait <= $urandom_range(0, 3);
                end else begin
                    bus.rvalid <= 1'b1;
                end
            end
            if (r_pend) begin
                if (r_wait == 0) begin
                    bus.rvalid <= 1'b1;
                    r_pend     <= 1'b0;
                end else begin
                    r_wait <= r_wait - 1;
                end
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    // Write side of the slave: each ready comes a programmable number of cycles after its valid.
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    int          aw_cnt, w_cnt;
    assign bus.awready = bus.awvalid && !aw_got && (aw_cnt >= aw_delay);
    assign bus.wready  = bus.wvalid && !w_got && (w_cnt >= w_delay);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            aw_a <= '0; w_d <= '0; w_s <= '0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
        end else begin
            if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
            if (bus.awvalid && bus.awready) begin
                aw_got <= 1'b1; aw_a <= bus.awaddr; aw_cnt <= 0;
                aw_log.push_back(bus.awaddr);
            end
            if (bus.wvalid && !bus.wready) w_cnt <= w_cnt + 1;
            if (bus.wvalid && bus.wready) begin
                w_got <= 1'b1; w_d <= bus.wdata; w_s <= bus.wstrb; w_cnt <= 0;
                wd_log.push_back(bus.wdata);
                ws_log.push_back(bus.wstrb);
            end
            if (aw_got && w_got && !bus.bvalid) begin
                bus.bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (wr_err_en && aw_a == wr_err_addr) begin
                    bus.bresp <= 2'b10;
                end else begin
                    bus.bresp <= 2'b00;
                    mem[aw_a[13:2]] <= merge(mem[aw_a[13:2]], w_d, w_s);
                end
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
    endtask

    // One CPU access; cyc counts cycles from the request cycle (0) to cpu_ready.
    task automatic access(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int cyc);
        bit done;
        done = 0; rd = '0; er = 1'b0; cyc = 0;
        @(negedge clk);
        ar_log.delete(); aw_log.delete(); wd_log.delete(); ws_log.delete();
        cpu_req = 1'b1; cpu_w_en = we; cpu_addr = a; cpu_wdata = wd;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (cpu_ready) begin
                rd = cpu_rdata; er = cpu_err; done = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (done) begin
            @(posedge clk);
            #1 cpu_req = 1'b0; cpu_w_en = 4'b0;
        end else begin
            check("access_timeout", 32'(done), 32'd1);
            cpu_req = 1'b0; cpu_w_en = 4'b0; rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            clear_model();
        end
    endtask

    task automatic do_read(input logic [31:0] a, input bit timed, output logic [31:0] rd);
        int          i;
        int unsigned t;
        bit          exp_hit, exp_err;
        logic [31:0] base, exp_data;
        logic        er;
        int          cyc;
        i        = (a / LINE_BYTES) % LINES;
        t        = a / SPAN;
        exp_hit  = ref_valid[i] && ref_tag[i] == t;
        base     = a - (a % LINE_BYTES);
        exp_err  = 0;
        exp_data = mem[a[13:2]];
        if (!exp_hit && rd_err_en)
            for (int k = 0; k < LW; k++) if (base + 32'(4*k) == rd_err_addr) exp_err = 1;
        access(4'b0000, a, '0, rd, er, cyc);
        check("rd_ar_count", 32'(ar_log.size()), exp_hit ? 32'd0 : 32'(LW));
        if (!exp_hit)
            for (int k = 0; k < ar_log.size() && k < LW; k++) check("rd_araddr", ar_log[k], base + 32'(4*k));
        check("rd_err", 32'(er), 32'(exp_err));
        if (!exp_err) check("rd_data", rd, exp_data);
        if (timed) check("rd_latency", 32'(cyc), exp_hit ? 32'd0 : 32'(2*LW + 1));
        if (!exp_hit) begin
            ref_valid[i] = !exp_err;
            ref_tag[i]   = t;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        bit          exp_err;
        exp_err = wr_err_en && ((a & 32'hFFFF_FFFC) == wr_err_addr);
        access(we, a, wd, rd, er, cyc);
        check("wr_aw_count", 32'(aw_log.size()), 32'd1);
        check("wr_w_count", 32'(wd_log.size()), 32'd1);
        check("wr_ar_count", 32'(ar_log.size()), 32'd0);
        if (aw_log.size() > 0) check("wr_awaddr", aw_log[0], a & 32'hFFFF_FFFC);
        if (wd_log.size() > 0) begin
            check("wr_wdata", wd_log[0], wd);
            check("wr_wstrb", 32'(ws_log[0]), 32'(we));
        end
        check("wr_err", 32'(er), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] rd, a;
        int n;

        clear_model();
        repeat (2) @(negedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_err", 32'(cpu_err), 32'd0);
        check("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("rst_rready", 32'(bus.rready), 32'd0);
        check("rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("rst_wvalid", 32'(bus.wvalid), 32'd0);
        check("rst_bready", 32'(bus.bready), 32'd0);
        check("rst_arprot", 32'(bus.arprot), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Cold miss, then a hit in the same line.
        do_read(32'h100, 1, rd);
        check("cold_rdata", rd, 32'h40);
        do_read(32'h108, 1, rd);
        check("hit_rdata", rd, 32'h42);

        // Store hit with AWREADY lagging WREADY by two cycles.
        aw_delay = 2; w_delay = 0;
        do_write(32'h104, 4'b0011, 32'hAABB_CCDD);
        do_read(32'h104, 1, rd);
        check("merge_rdata", rd, 32'h0000_CCDD);
        aw_delay = 0;

        // Write miss allocates nothing.
        do_write(32'h2000, 4'b1111, 32'h1234_5678);
        do_read(32'h2000, 1, rd);
        check("wmiss_rdata", rd, 32'h1234_5678);

        // SLVERR on word 2 leaves the line invalid; the re-read refetches.
        rd_err_en = 1; rd_err_addr = 32'h308;
        do_read(32'h300, 1, rd);
        rd_err_en = 0;
        do_read(32'h300, 1, rd);

        // Invalidate in IDLE.
        @(negedge clk); inv = 1'b1;
        @(negedge clk); inv = 1'b0;
        clear_model();
        do_read(32'h300, 1, rd);
        do_read(32'h2000, 1, rd);

        // Invalidate together with a would-be hit: no completion that cycle.
        @(negedge clk);
        inv = 1'b1; cpu_req = 1'b1; cpu_w_en = 4'b0; cpu_addr = 32'h2000;
        #1 check("inv_blocks_hit", 32'(cpu_ready), 32'd0);
        @(negedge clk); inv = 1'b0;
        clear_model();
        do_read(32'h2000, 0, rd);

        // Reset in the middle of a refill.
        @(negedge clk);
        cpu_req = 1'b1; cpu_w_en = 4'b0; cpu_addr = 32'h500;
        n = 0;
        while (!bus.rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_rd_r", 32'(bus.rready), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("mid_rst_rready", 32'(bus.rready), 32'd0);
        check("mid_rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("mid_rst_bready", 32'(bus.bready), 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        do_read(32'h100, 1, rd);

        // Random mix with stalling slave and error addresses.
        stall = 1;
        rd_err_en = 1; rd_err_addr = 32'h31C;
        wr_err_en = 1; wr_err_addr = 32'h210;
        for (int k = 0; k < 80; k++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
            case ($urandom_range(0, 9))
                0: begin
                    @(negedge clk); inv = 1'b1;
                    @(negedge clk); inv = 1'b0;
                    clear_model();
                end
                1, 2, 3: begin
                    aw_delay = $urandom_range(0, 3);
                    w_delay  = $urandom_range(0, 3);
                    do_write(a, 4'($urandom_range(1, 15)), $urandom);
                end
                default: do_read(a, 0, rd);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
